mc_controller: RTL

Multi-cycle control FSM that sequences the shared MIPS datapath (single ALU, single unified memory port) through fetch, decode, execute, memory and write-back steps. Replaces the single-cycle combinational controller when the datapath is built multi-cycle. It sits beside the datapath and consumes `opcode`/`funct` and status flags. It drives per-state write enables, mux selects and a request/ready memory handshake tolerating wait states.

---
 rtl/mc_pkg.sv | 68 ++++++
 rtl/mc_decode.sv | 43 ++++
 rtl/mc_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller: FSM states,
// instruction classes, opcode/funct constants and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DCD,
    S_EXE,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BR,
    S_JMP
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE,
    CL_IMM_ADD,
    CL_IMM_OR,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_ILLEGAL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_GPR = 2'b11;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_RA  = 2'b10;

  localparam logic [1:0] M2R_ALU    = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_OR     = 2'b10;
  localparam logic [1:0] ALU_SLT    = 2'b11;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct to instruction-class decode; zero latency, no flow control.
// Also yields the R-type ALU operation so the FSM never looks at raw IR bits.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [1:0] r_aluctr
);

  always_comb begin
    iclass   = CL_ILLEGAL;
    r_aluctr = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CL_RTYPE;
          FN_SUBU: begin
            iclass   = CL_RTYPE;
            r_aluctr = ALU_SUB;
          end
          FN_SLT: begin
            iclass   = CL_RTYPE;
            r_aluctr = ALU_SLT;
          end
          FN_JR:   iclass = CL_JR;
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_ADDI: iclass = CL_IMM_ADD;
      OP_ORI:  iclass = CL_IMM_OR;
      OP_LUI:  iclass = CL_LUI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  iclass = CL_BEQ;
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM; 3-5 cycles per instruction, +1 per mem_rdy-low wait.
// Memory requests hold until mem_rdy; perf counters built only with MC_PERF_CNT_EN.
module mc_controller
  import mc_pkg::*;
#(
  parameter int PERF_W = 32
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              ov,
  input  logic              mem_rdy,
  output logic              mem_req,
  output logic              IorD,
  output logic              MemWrite,
  output logic              IRWr,
  output logic              PCWr,
  output logic [1:0]        pc_sel,
  output logic              RegWrite,
  output logic [1:0]        RegDst,
  output logic [1:0]        MemtoReg,
  output logic              ALUSrc,
  output logic [1:0]        ALUctr,
  output logic [1:0]        ExtOp,
  output logic              illegal,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
);

  state_t     state;
  iclass_t    iclass;
  logic [1:0] r_aluctr;

  mc_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (iclass),
    .r_aluctr (r_aluctr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (mem_rdy) state <= S_DCD;
        S_DCD: begin
          case (iclass)
            CL_BEQ:               state <= S_BR;
            CL_J, CL_JAL, CL_JR:  state <= S_JMP;
            CL_ILLEGAL:           state <= S_FETCH;
            default:              state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (iclass)
            CL_LW:   state <= S_MEM_RD;
            CL_SW:   state <= S_MEM_WR;
            default: state <= S_WB_ALU;
          endcase
        end
        S_MEM_RD: if (mem_rdy) state <= S_WB_MEM;
        S_MEM_WR: if (mem_rdy) state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Decoded straight from the state register; gating on rst keeps every
  // enable, and mem_req in particular, low the instant reset asserts.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    pc_sel   = PC_SEL_PC4;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALU;
    ALUSrc   = 1'b0;
    ALUctr   = ALU_ADD;
    ExtOp    = EXT_ZERO;
    illegal  = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            IRWr = 1'b1;
            PCWr = 1'b1;
          end
        end
        S_DCD: illegal = (iclass == CL_ILLEGAL);
        S_EXE: begin
          case (iclass)
            CL_RTYPE: ALUctr = r_aluctr;
            CL_IMM_ADD, CL_LW, CL_SW: begin
              ALUSrc = 1'b1;
              ExtOp  = EXT_SIGN;
            end
            CL_IMM_OR: begin
              ALUSrc = 1'b1;
              ALUctr = ALU_OR;
            end
            CL_LUI: begin
              ALUSrc = 1'b1;
              ALUctr = ALU_OR;
              ExtOp  = EXT_LUI;
            end
            default: ;
          endcase
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_WB_ALU: begin
          RegWrite = !((iclass == CL_IMM_ADD) && ov);
          RegDst   = (iclass == CL_RTYPE) ? REGDST_RD : REGDST_RT;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = M2R_MDR;
        end
        S_BR: begin
          ALUctr = ALU_SUB;
          PCWr   = zero;
          pc_sel = PC_SEL_BR;
        end
        S_JMP: begin
          PCWr = 1'b1;
          if (iclass == CL_JR) begin
            pc_sel = PC_SEL_GPR;
          end else begin
            pc_sel = PC_SEL_JMP;
          end
          if (iclass == CL_JAL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = M2R_PC;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic              retire;
  logic [PERF_W-1:0] cycle_q;
  logic [PERF_W-1:0] instr_q;

  // A suppressed addi still leaves through WB_ALU, so it counts as retired.
  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) ||
                  (state == S_BR)     || (state == S_JMP)    ||
                  ((state == S_MEM_WR) && mem_rdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + PERF_W'(1);
      if (retire) instr_q <= instr_q + PERF_W'(1);
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule
